multicycle_sequencer: RTL

//  Master state sequencer for the multicycle RV32 datapath. It drives the 4-bit estado bus that
//  the control-signal generator samples, and owns PC, IR, instruction/data memory handshakes and

---
 rtl/multicycle_sequencer_pkg.sv | 53 +++++
 rtl/multicycle_sequencer_pc_unit.sv | 47 ++++
 rtl/multicycle_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// ============================================================================
// Package : multicycle_sequencer_pkg
// Brief   : State encodings, instruction-class constants and small decode
//           helpers shared by the multicycle RV32 sequencer and its PC unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_sequencer_pkg;

  // Default datapath / instruction width.
  localparam int XLEN_DEF = 32;

  // Sequencer states. The encoding is the estado bus seen by the control
  // generator, so these values are part of the external interface.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_FETCH  = 4'b0001,
    ST_DECODE = 4'b0010,
    ST_EXEC   = 4'b0100,
    ST_MEM    = 4'b1000,
    ST_WB     = 4'b1111,
    ST_COMMIT = 4'b0011,
    ST_HALT   = 4'b1110
  } state_e;

  // Instruction class, taken from IR[6:4].
  localparam logic [2:0] TIPO_LW   = 3'b000;
  localparam logic [2:0] TIPO_ADDI = 3'b001;
  localparam logic [2:0] TIPO_SW   = 3'b010;
  localparam logic [2:0] TIPO_R    = 3'b011;
  localparam logic [2:0] TIPO_B    = 3'b110;

  // Branch flavours resolved by the sequencer (IR[14:12]).
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // True for the instruction classes the datapath knows how to execute.
  function automatic logic tipo_legal(input logic [2:0] tipo);
    return (tipo == TIPO_LW) || (tipo == TIPO_ADDI) || (tipo == TIPO_SW) ||
           (tipo == TIPO_R)  || (tipo == TIPO_B);
  endfunction

  // Branch decision for a conditional branch. Unsupported conditions are
  // treated as not taken so the instruction simply falls through.
  function automatic logic branch_cond(input logic [2:0] funct3, input logic zero);
    return ((funct3 == F3_BEQ) &&  zero) ||
           ((funct3 == F3_BNE) && !zero);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_sequencer_pc_unit.sv
// ============================================================================
// Module  : multicycle_sequencer_pc_unit
// Brief   : Program counter register with B-type immediate extraction and
//           next-PC selection (pc+4 or pc+imm_b, wrapping mod 2^XLEN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,     // update PC this cycle (COMMIT)
  input  logic            i_taken,    // select the branch target
  input  logic [6:0]      i_ir_hi,    // IR[31:25]
  input  logic [4:0]      i_ir_lo,    // IR[11:7]
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [12:0]     w_imm13;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_pc_next;

  // B-type immediate: {IR[31], IR[7], IR[30:25], IR[11:8], 0}, sign-extended.
  assign w_imm13   = {i_ir_hi[6], i_ir_lo[0], i_ir_hi[5:0], i_ir_lo[4:1], 1'b0};
  assign w_imm_b   = {{(XLEN-13){w_imm13[12]}}, w_imm13};
  assign w_pc_inc  = i_taken ? w_imm_b : XLEN'(4);
  assign w_pc_next = r_pc + w_pc_inc;

  // PC register: reset vector on reset, advances only when the sequencer commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module  : multicycle_sequencer
// Brief   : Master state sequencer for the multicycle RV32 datapath. Produces
//           the estado bus, owns IR, the memory handshakes and branch
//           resolution, and drives the PC unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  input  logic            dmem_ack,
  input  logic            zero,
  output logic [XLEN-1:0] instr,
  output logic [2:0]      tipo,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [3:0]      estado,
  output logic [XLEN-1:0] pc,
  output logic            retired,
  output logic            halted
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_ir;
  logic            r_branch_taken;
  logic            r_imem_req;
  logic            r_dmem_req;
  logic            r_retired;
  logic            r_halted;
  logic [2:0]      w_tipo;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_pc;

  assign w_tipo   = r_ir[6:4];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];

  // Next-state selection; every state not listed as multi-cycle lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_ack) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = tipo_legal(w_tipo) ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        if ((w_tipo == TIPO_LW) || (w_tipo == TIPO_SW)) begin
          w_state_nxt = ST_MEM;
        end else if (w_tipo == TIPO_B) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      // Stores have nothing to write back; loads go through WB.
      ST_MEM:    if (dmem_ack) w_state_nxt = (w_tipo == TIPO_SW) ? ST_COMMIT : ST_WB;
      ST_WB:     w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_FETCH;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, IR capture, branch resolution and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ir           <= '0;
      r_branch_taken <= 1'b0;
      r_imem_req     <= 1'b0;
      r_dmem_req     <= 1'b0;
      r_retired      <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Outputs are derived from the next state so they line up with estado.
      r_imem_req <= (w_state_nxt == ST_FETCH);
      r_dmem_req <= (w_state_nxt == ST_MEM);
      r_retired  <= (w_state_nxt == ST_COMMIT);
      r_halted   <= (w_state_nxt == ST_HALT);

      if ((r_state == ST_FETCH) && imem_ack) begin
        r_ir <= imem_rdata;
      end

      // zero is only meaningful in EXEC, when the ALU has the branch operands.
      if (r_state == ST_EXEC) begin
        r_branch_taken <= (w_tipo == TIPO_B) && branch_cond(w_funct3, zero);
      end else if (r_state == ST_COMMIT) begin
        r_branch_taken <= 1'b0;
      end
    end
  end

  multicycle_sequencer_pc_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk     (clk),
    .reset   (reset),
    .i_load  (r_state == ST_COMMIT),
    .i_taken (r_branch_taken),
    .i_ir_hi (r_ir[31:25]),
    .i_ir_lo (r_ir[11:7]),
    .o_pc    (w_pc)
  );

  assign imem_req  = r_imem_req;
  assign imem_addr = w_pc;
  assign dmem_req  = r_dmem_req;
  assign instr     = r_ir;
  assign tipo      = w_tipo;
  assign funct3    = w_funct3;
  assign funct7    = w_funct7;
  assign estado    = r_state;
  assign pc        = w_pc;
  assign retired   = r_retired;
  assign halted    = r_halted;

endmodule

`default_nettype wire
